// File: rtl/mem_req_arbiter_if.sv
// Bundle of the IFU, LSU and downstream memory handshake signals around mem_req_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding requesters and memory.
interface mem_req_arbiter_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_resp_data;
    logic        ifu_resp_err;

    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_wen;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_resp_data;
    logic        lsu_resp_err;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
        input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
        output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
        output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
        input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction at a time, with a WAIT-state watchdog.
// Define MEM_ARB_RR_EN for round-robin arbitration on simultaneous requests; otherwise LSU wins ties.
module mem_req_arbiter #(
    parameter int unsigned MAX_WAIT = 255
) (
    input logic              clock,
    input logic              reset,
    mem_req_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
    typedef enum logic {OWNER_IFU = 1'b0, OWNER_LSU = 1'b1} owner_e;

    localparam logic [15:0] LastWait = 16'(MAX_WAIT - 1);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [15:0] cnt_q, cnt_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  wmask_q, wmask_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic        lsu_wins;
    logic        ifu_ready;
    logic        lsu_ready;
`ifdef MEM_ARB_RR_EN
    owner_e      last_owner_q, last_owner_d;
`endif

    // A lone requester always wins; a tie goes to the LSU unless round-robin says otherwise.
    always_comb begin
        lsu_wins = bus.lsu_req_valid;
`ifdef MEM_ARB_RR_EN
        if (bus.lsu_req_valid && bus.ifu_req_valid) begin
            lsu_wins = (last_owner_q == OWNER_IFU);
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        data_d    = data_q;
        err_d     = err_q;
        ifu_ready = 1'b0;
        lsu_ready = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_owner_d = last_owner_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Ready is held low while reset is asserted so no grant is offered then.
                if (reset && (bus.lsu_req_valid || bus.ifu_req_valid)) begin
                    state_d = REQ;
                    if (lsu_wins) begin
                        lsu_ready = 1'b1;
                        owner_d   = OWNER_LSU;
                        wen_d     = bus.lsu_wen;
                        addr_d    = bus.lsu_addr;
                        wdata_d   = bus.lsu_wdata;
                        wmask_d   = bus.lsu_wmask;
                    end else begin
                        ifu_ready = 1'b1;
                        owner_d   = OWNER_IFU;
                        wen_d     = 1'b0;
                        addr_d    = bus.ifu_addr;
                        wdata_d   = 32'd0;
                        wmask_d   = 8'd0;
                    end
`ifdef MEM_ARB_RR_EN
                    last_owner_d = lsu_wins ? OWNER_LSU : OWNER_IFU;
`endif
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = WAIT;
                    cnt_d   = 16'd0;
                end
            end
            WAIT: begin
                // A response arriving on the final allowed cycle still beats the watchdog.
                if (bus.mem_resp_valid) begin
                    data_d  = wen_q ? 32'd0 : bus.mem_resp_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == LastWait) begin
                    data_d  = 32'd0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= OWNER_IFU;
            cnt_q   <= 16'd0;
            wen_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wmask_q <= 8'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= OWNER_IFU;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    assign bus.ifu_req_ready  = ifu_ready;
    assign bus.lsu_req_ready  = lsu_ready;

    assign bus.mem_req_valid  = (state_q == REQ);
    assign bus.mem_wen        = wen_q;
    assign bus.mem_addr       = addr_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.mem_wmask      = wmask_q;

    assign bus.ifu_resp_valid = (state_q == RESP) && (owner_q == OWNER_IFU);
    assign bus.ifu_resp_data  = bus.ifu_resp_valid ? data_q : 32'd0;
    assign bus.ifu_resp_err   = bus.ifu_resp_valid & err_q;

    assign bus.lsu_resp_valid = (state_q == RESP) && (owner_q == OWNER_LSU);
    assign bus.lsu_resp_data  = bus.lsu_resp_valid ? data_q : 32'd0;
    assign bus.lsu_resp_err   = bus.lsu_resp_valid & err_q;
endmodule
